syn_fifo: RTL and testbench

SYN_FIFO -- requirements
Module: syn_fifo

---
 rtl/syn_fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 27 ++
 rtl/syn_fifo.sv | 101 ++++++++++
 tb/tb_syn_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared constants for the synchronous FIFO and its storage array.
package syn_fifo_pkg;

    // Default data word width in bits.
    localparam int DEFAULT_WIDTH     = 8;

    // Default storage depth in words; must be a power of two, at least 2.
    localparam int DEFAULT_FIFO_SIZE = 16;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and an
// address-indexed combinational read port. Contents are not reset.
module fifo_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/syn_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational full/empty flags,
// registered read data and one-cycle overflow/underflow pulses.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FIFO_SIZE = DEFAULT_FIFO_SIZE,
    parameter int PTR_WIDTH = $clog2(FIFO_SIZE)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             overflow,
    output logic             empty,
    output logic             underflow
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [WIDTH-1:0]   w_mem_rdata;

    // Same address with matching wrap bits means no words held; with
    // differing wrap bits the writer is a full lap ahead.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]) &&
                     (r_wr_ptr[PTR_WIDTH]     != r_rd_ptr[PTR_WIDTH]);

    // Acceptance uses the pre-edge flags, so a read cannot make room for a
    // write in the same cycle, nor a write feed a read.
    assign w_wr_ok = wr_en && !w_full;
    assign w_rd_ok = rd_en && !w_empty;

    fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (FIFO_SIZE),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_wr_en (w_wr_ok),
        .i_waddr (r_wr_ptr[PTR_WIDTH-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rd_ptr[PTR_WIDTH-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Advance each pointer on an accepted access; wraps modulo 2*FIFO_SIZE.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Register the head word on an accepted read; hold otherwise.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_rdata <= '0;
        end else if (w_rd_ok) begin
            r_rdata <= w_mem_rdata;
        end
    end

    // Flag a rejected request for exactly the following cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    assign rdata     = r_rdata;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_syn_fifo.sv
module tb_syn_fifo;

    logic       clk;
    logic       res;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       full;
    logic       overflow;
    logic       empty;
    logic       underflow;

    int checks;
    int failures;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] rdata;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t       vecs[36];
    logic [7:0] fill_data[16];

    syn_fifo dut (
        .clk       (clk),
        .res       (res),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .full      (full),
        .overflow  (overflow),
        .empty     (empty),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] e_rdata, input logic e_full,
                           input logic e_empty, input logic e_ovf, input logic e_udf);
        chk({name, ".rdata"},     {24'd0, rdata},     {24'd0, e_rdata});
        chk({name, ".full"},      {31'd0, full},      {31'd0, e_full});
        chk({name, ".empty"},     {31'd0, empty},     {31'd0, e_empty});
        chk({name, ".overflow"},  {31'd0, overflow},  {31'd0, e_ovf});
        chk({name, ".underflow"}, {31'd0, underflow}, {31'd0, e_udf});
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] wd);
        wr_en = wr;
        rd_en = rd;
        wdata = wd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        res = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        res   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;

        fill_data = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12,
                      8'h01, 8'h0D, 8'h76, 8'h3D, 8'hED, 8'h8C, 8'hF9, 8'hC6};

        // Fill 16, rejected write, idle, drain 16, rejected read, idle.
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 1'b0, fill_data[i], 8'h00, (i == 15), 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++)
            vecs[18 + i] = '{1'b0, 1'b1, 8'h00, fill_data[i], 1'b0, (i == 15), 1'b0, 1'b0};
        vecs[34] = '{1'b0, 1'b1, 8'h00, 8'hC6, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[35] = '{1'b0, 1'b0, 8'h00, 8'hC6, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held 2 cycles with requests present: all must be ignored.
        do_reset();
        chk_all("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 36; i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].wd);
            chk_all($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].full,
                    vecs[i].empty, vecs[i].ovf, vecs[i].udf);
        end

        // Simultaneous access with 8 stored, crossing the pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h10 + 8'(i));
        chk_all("sim_pre", 8'hC6, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            cycle(1'b1, 1'b1, 8'h40 + 8'(j));
            chk_all($sformatf("sim%0d", j),
                    (j < 8) ? 8'h10 + 8'(j) : 8'h40 + 8'(j - 8), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk_all($sformatf("sim_drain%0d", i), 8'h40 + 8'(12 + i), 1'b0, (i == 7), 1'b0, 1'b0);
        end

        // Write+read while empty: write lands, read rejected.
        cycle(1'b1, 1'b1, 8'h77);
        chk_all("wr_rd_empty", 8'h4B + 8'h08, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h00);
        chk_all("wr_rd_empty_rd", 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);

        // Write+read while full: read completes, write rejected.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'hB0 + 8'(i));
        chk_all("refill", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hEE);
        chk_all("wr_rd_full", 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk_all($sformatf("full_drain%0d", i), 8'hB0 + 8'(i), 1'b0, (i == 15), 1'b0, 1'b0);
        end

        // Reset mid-operation, asserted between edges.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h30 + 8'(i));
        chk_all("pre_mid_reset", 8'hBF, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        res = 1'b0;
        #1;
        chk_all("mid_reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        res = 1'b1;
        cycle(1'b0, 1'b1, 8'h00);
        chk_all("post_reset_rd", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00);
        chk_all("post_reset_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
